// File: rtl/s35932_sig_scheduler.sv
// Round-robin scheduler that grants one requester at a time, folds its beats into a shared
// rotate-XOR signature and publishes one signature (or an abort pulse) per packet.
module s35932_sig_scheduler #(
    parameter int N_REQ    = 4,
    parameter int W        = 32,
    parameter int MAX_IDLE = 15
) (
    input  logic               CK,
    input  logic               RESET,
    input  logic               TM0,
    input  logic               TM1,
    input  logic [N_REQ-1:0]   REQ_VALID,
    input  logic [N_REQ*W-1:0] REQ_DATA,
    input  logic [N_REQ-1:0]   REQ_LAST,
    output logic [N_REQ-1:0]   GNT,
    output logic [W-1:0]       SIG_OUT,
    output logic               SIG_VALID,
    output logic [2:0]         SIG_OWNER,
    output logic               ABORT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_BUSY,
        S_DONE,
        S_ABT
    } state_e;

    localparam logic [7:0] MAX_IDLE_C = 8'(MAX_IDLE);

    state_e           state_q;
    logic [2:0]       rr_q;
    logic [2:0]       owner_q;
    logic [7:0]       idle_q;
    logic [W-1:0]     acc_q;
    logic [W-1:0]     acc_d;
    logic [N_REQ-1:0] gnt_q;
    logic [W-1:0]     sig_q;
    logic             sigValid_q;
    logic [2:0]       sigOwner_q;
    logic             abort_q;

    logic [7:0]       validExt;
    logic [7:0]       lastExt;
    logic [W-1:0]     dataArr [8];
    logic [3:0]       cand;
    logic [2:0]       pickIdx;
    logic             pickFound;
    logic [2:0]       nextRr;
    logic [W-1:0]     beat;
    logic             beatAccepted;
    logic             idleExpired;

    // Requester lanes are widened to eight so a 3-bit owner index always addresses a real slot.
    assign validExt = 8'(REQ_VALID);
    assign lastExt  = 8'(REQ_LAST);

    for (genvar g = 0; g < 8; g++) begin : gen_lane
        if (g < N_REQ) begin : gen_used
            assign dataArr[g] = REQ_DATA[g*W +: W];
        end else begin : gen_unused
            assign dataArr[g] = '0;
        end
    end

    // Highest-to-lowest scan so the candidate nearest the rr pointer is the one that sticks.
    always_comb begin
        cand      = '0;
        pickIdx   = '0;
        pickFound = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_q} + 4'(k);
            if (cand >= 4'(N_REQ)) begin
                cand = cand - 4'(N_REQ);
            end
            if (validExt[cand[2:0]]) begin
                pickFound = 1'b1;
                pickIdx   = cand[2:0];
            end
        end
    end

    assign beat         = dataArr[owner_q] ^ {{(W-1){1'b0}}, TM1};
    assign acc_d        = TM0 ? ({acc_q[W-2:0], acc_q[W-1]} ^ beat) : beat;
    assign beatAccepted = validExt[owner_q];
    assign idleExpired  = (idle_q + 8'd1) == MAX_IDLE_C;
    assign nextRr       = (owner_q == 3'(N_REQ - 1)) ? 3'd0 : owner_q + 3'd1;

    always_ff @(posedge CK) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            rr_q       <= '0;
            owner_q    <= '0;
            idle_q     <= '0;
            acc_q      <= '0;
            gnt_q      <= '0;
            sig_q      <= '0;
            sigValid_q <= 1'b0;
            sigOwner_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            sigValid_q <= 1'b0;
            abort_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|REQ_VALID) begin
                        state_q <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (pickFound) begin
                        owner_q <= pickIdx;
                        gnt_q   <= N_REQ'(8'd1 << pickIdx);
                        acc_q   <= '0;
                        idle_q  <= '0;
                        state_q <= S_BUSY;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                // Grant holds until the owner's LAST beat or until it stalls too long.
                S_BUSY: begin
                    if (beatAccepted) begin
                        acc_q  <= acc_d;
                        idle_q <= '0;
                        if (lastExt[owner_q]) begin
                            gnt_q   <= '0;
                            state_q <= S_DONE;
                        end
                    end else if (idleExpired) begin
                        gnt_q   <= '0;
                        state_q <= S_ABT;
                    end else begin
                        idle_q <= idle_q + 8'd1;
                    end
                end
                S_DONE: begin
                    sig_q      <= acc_q;
                    sigOwner_q <= owner_q;
                    sigValid_q <= 1'b1;
                    rr_q       <= nextRr;
                    state_q    <= S_IDLE;
                end
                S_ABT: begin
                    abort_q <= 1'b1;
                    rr_q    <= nextRr;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign GNT       = gnt_q;
    assign SIG_OUT   = sig_q;
    assign SIG_VALID = sigValid_q;
    assign SIG_OWNER = sigOwner_q;
    assign ABORT     = abort_q;

endmodule

// File: tb/tb_s35932_sig_scheduler.sv
// Bench for s35932_sig_scheduler: directed scenarios with literal expectations, then random
// four-requester traffic, all compared every cycle against an event-scheduled packet model.
`timescale 1ns/1ps
module tb_s35932_sig_scheduler;

   localparam int N    = 4;
   localparam int W    = 32;
   localparam int MAXI = 15;

   logic           CK        = 1'b0;
   logic           RESET     = 1'b0;
   logic           TM0       = 1'b0;
   logic           TM1       = 1'b0;
   logic [N-1:0]   REQ_VALID = '0;
   logic [N-1:0]   REQ_LAST  = '0;
   logic [N*W-1:0] REQ_DATA  = '0;
   logic [N-1:0]   GNT;
   logic [W-1:0]   SIG_OUT;
   logic           SIG_VALID;
   logic [2:0]     SIG_OWNER;
   logic           ABORT;

   int checks = 0;
   int errors = 0;

   always #5 CK = ~CK;

   s35932_sig_scheduler #(.N_REQ(N), .W(W), .MAX_IDLE(MAXI)) dut (
      .CK(CK), .RESET(RESET), .TM0(TM0), .TM1(TM1),
      .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA), .REQ_LAST(REQ_LAST),
      .GNT(GNT), .SIG_OUT(SIG_OUT), .SIG_VALID(SIG_VALID),
      .SIG_OWNER(SIG_OWNER), .ABORT(ABORT)
   );

   // Reference model: packet-level bookkeeping with scheduled events keyed by edge number.
   bit           modelOn = 1'b0;
   int           edgeNo  = 0;
   int           mOwner  = -1;
   int           arbEdge = -1;
   int           pubEdge = -1;
   int           pubOwner = 0;
   bit           pubIsSig = 1'b0;
   int           mIdle   = 0;
   int           mRr     = 0;
   logic [W-1:0] mAcc    = '0;
   logic [N-1:0] expGnt  = '0;
   logic [W-1:0] expSigOut = '0;
   logic         expSigValid = 1'b0;
   logic         expAbort    = 1'b0;
   logic [2:0]   expOwner    = '0;
   int           waitCnt [N];

   task automatic checkOutput(input string name, input logic [W-1:0] actual,
                              input logic [W-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic closePacket(input bit isSig);
      expGnt   = '0;
      pubEdge  = edgeNo + 1;
      pubIsSig = isSig;
      pubOwner = mOwner;
      mOwner   = -1;
   endtask

   // Advance the model across the coming rising edge using the inputs now applied.
   task automatic stepModel();
      logic [W-1:0] beat;
      int pick;
      expSigValid = 1'b0;
      expAbort    = 1'b0;
      if (!RESET) begin
         modelOn   = 1'b1;
         expGnt    = '0;
         expSigOut = '0;
         expOwner  = '0;
         mRr       = 0;
         mOwner    = -1;
         arbEdge   = -1;
         pubEdge   = -1;
         mAcc      = '0;
         for (int k = 0; k < N; k++) waitCnt[k] = 0;
      end else if (modelOn) begin
         if (edgeNo == pubEdge) begin
            if (pubIsSig) begin
               expSigValid = 1'b1;
               expSigOut   = mAcc;
               expOwner    = 3'(pubOwner);
            end else begin
               expAbort = 1'b1;
            end
            mRr     = (pubOwner + 1) % N;
            pubEdge = -1;
         end else if (mOwner >= 0) begin
            if (REQ_VALID[mOwner]) begin
               beat  = REQ_DATA[mOwner*W +: W] ^ W'(TM1);
               mAcc  = TM0 ? (((mAcc << 1) | (mAcc >> (W - 1))) ^ beat) : beat;
               mIdle = 0;
               if (REQ_LAST[mOwner]) closePacket(1'b1);
            end else begin
               mIdle++;
               if (mIdle == MAXI) closePacket(1'b0);
            end
         end else if (edgeNo == arbEdge) begin
            arbEdge = -1;
            pick = -1;
            for (int k = 0; k < N; k++) begin
               if (pick < 0 && REQ_VALID[(mRr + k) % N]) pick = (mRr + k) % N;
            end
            if (pick >= 0) begin
               checkOutput("no_starvation", 32'(waitCnt[pick] < N), 32'd1);
               for (int k = 0; k < N; k++) begin
                  if (k == pick || !REQ_VALID[k]) waitCnt[k] = 0;
                  else waitCnt[k]++;
               end
               mOwner = pick;
               mAcc   = '0;
               mIdle  = 0;
               expGnt = N'(1) << pick;
            end
         end else if (REQ_VALID != '0) begin
            arbEdge = edgeNo + 1;
         end
      end
      edgeNo++;
   endtask

   // Compare every cycle away from the active edge, then step the model for the next edge.
   always @(negedge CK) begin
      if (modelOn) begin
         checkOutput("gnt", 32'(GNT), 32'(expGnt));
         checkOutput("sig_valid", 32'(SIG_VALID), 32'(expSigValid));
         checkOutput("abort", 32'(ABORT), 32'(expAbort));
         checkOutput("sig_out", SIG_OUT, expSigOut);
         checkOutput("sig_owner", 32'(SIG_OWNER), 32'(expOwner));
      end
      stepModel();
   end

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic applyStimulus(input int r, input bit v, input bit l, input logic [W-1:0] d);
      REQ_VALID[r]       = v;
      REQ_LAST[r]        = l;
      REQ_DATA[r*W +: W] = d;
   endtask

   task automatic waitGrant(input int r, input string name);
      int n = 0;
      while (GNT == '0 && n < 40) begin
         tick();
         n++;
      end
      checkOutput(name, 32'(GNT), 32'(1) << r);
   endtask

   int           left  [N];
   int           stall [N];
   logic [W-1:0] hold  [N];
   logic [N-1:0] gntSnap;
   logic [N-1:0] accSnap;
   bit           v;

   initial begin
      RESET = 1'b0;
      tick();
      tick();
      RESET = 1'b1;

      // Two-beat packet in accumulate mode cancels to zero.
      TM0 = 1'b1; TM1 = 1'b0;
      applyStimulus(0, 1, 0, 32'h0000_0001);
      waitGrant(0, "t1_grant");
      tick();
      applyStimulus(0, 1, 1, 32'h0000_0002);
      tick();
      applyStimulus(0, 0, 0, '0);
      checkOutput("t1_gnt_released", 32'(GNT), 32'd0);
      tick();
      checkOutput("t1_sig_valid", 32'(SIG_VALID), 32'd1);
      checkOutput("t1_sig_out", SIG_OUT, 32'h0000_0000);
      checkOutput("t1_owner", 32'(SIG_OWNER), 32'd0);
      checkOutput("t1_model_sig", expSigOut, 32'h0000_0000);
      applyStimulus(0, 1, 1, 32'h0000_0011);
      applyStimulus(1, 1, 1, 32'h0000_0022);
      waitGrant(1, "t1_rr_next");
      tick();
      applyStimulus(1, 0, 0, '0);
      waitGrant(0, "t1_then_req0");
      tick();
      applyStimulus(0, 0, 0, '0);

      // Arbitration order after reset, then wrap past the top requester.
      RESET = 1'b0;
      tick();
      RESET = 1'b1;
      applyStimulus(0, 1, 1, 32'h1000_0000);
      applyStimulus(2, 1, 1, 32'h3000_0000);
      waitGrant(0, "t2_first");
      tick();
      applyStimulus(0, 0, 0, '0);
      applyStimulus(1, 1, 1, 32'h2000_0000);
      waitGrant(1, "t2_second");
      tick();
      applyStimulus(1, 0, 0, '0);
      waitGrant(2, "t2_third");
      tick();
      applyStimulus(2, 0, 0, '0);
      applyStimulus(0, 1, 1, 32'h0000_00F0);
      applyStimulus(3, 1, 1, 32'h0000_000F);
      waitGrant(3, "t2_wrap_3");
      tick();
      applyStimulus(3, 0, 0, '0);
      waitGrant(0, "t2_wrap_0");
      tick();
      applyStimulus(0, 0, 0, '0);

      // Load mode with bit-0 inversion on a single-beat packet.
      TM0 = 1'b0; TM1 = 1'b1;
      applyStimulus(3, 1, 1, 32'hA5A5_A5A4);
      waitGrant(3, "t3_grant");
      tick();
      applyStimulus(3, 0, 0, '0);
      tick();
      checkOutput("t3_sig_valid", 32'(SIG_VALID), 32'd1);
      checkOutput("t3_sig_out", SIG_OUT, 32'hA5A5_A5A5);
      checkOutput("t3_owner", 32'(SIG_OWNER), 32'd3);
      checkOutput("t3_model_sig", expSigOut, 32'hA5A5_A5A5);

      // Stalled packet is dropped after MAX_IDLE idle cycles.
      TM0 = 1'b1; TM1 = 1'b0;
      applyStimulus(1, 1, 0, 32'h0000_1234);
      waitGrant(1, "t4_grant");
      tick();
      applyStimulus(1, 0, 1, '0);
      for (int i = 0; i < MAXI - 1; i++) tick();
      checkOutput("t4_gnt_held", 32'(GNT), 32'd2);
      tick();
      checkOutput("t4_gnt_dropped", 32'(GNT), 32'd0);
      tick();
      checkOutput("t4_abort", 32'(ABORT), 32'd1);
      checkOutput("t4_sig_kept", SIG_OUT, 32'hA5A5_A5A5);
      applyStimulus(1, 0, 0, '0);
      applyStimulus(0, 1, 1, 32'h0000_0005);
      applyStimulus(2, 1, 1, 32'h0000_0006);
      waitGrant(2, "t4_search_from_2");
      tick();
      applyStimulus(2, 0, 0, '0);
      waitGrant(0, "t4_then_req0");
      tick();
      applyStimulus(0, 0, 0, '0);

      // Reset in the middle of a packet discards it.
      applyStimulus(2, 1, 0, 32'h0000_0077);
      waitGrant(2, "t5_grant");
      tick();
      RESET = 1'b0;
      tick();
      checkOutput("t5_gnt", 32'(GNT), 32'd0);
      checkOutput("t5_sig_out", SIG_OUT, 32'd0);
      checkOutput("t5_sig_valid", 32'(SIG_VALID), 32'd0);
      checkOutput("t5_abort", 32'(ABORT), 32'd0);
      checkOutput("t5_owner", 32'(SIG_OWNER), 32'd0);
      RESET = 1'b1;
      applyStimulus(2, 0, 0, '0);
      tick();
      checkOutput("t5_no_pulse", 32'({SIG_VALID, ABORT}), 32'd0);
      applyStimulus(0, 1, 1, 32'h0000_0101);
      applyStimulus(1, 1, 1, 32'h0000_0202);
      waitGrant(0, "t5_rr_reset");
      tick();
      applyStimulus(0, 0, 0, '0);
      waitGrant(1, "t5_then_req1");
      tick();
      applyStimulus(1, 0, 0, '0);
      for (int i = 0; i < 5; i++) tick();

      // Random traffic: waiting requesters hold VALID, granted ones may stall or time out.
      for (int r = 0; r < N; r++) begin
         left[r]  = 0;
         stall[r] = 0;
         hold[r]  = '0;
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge CK);
         gntSnap = GNT;
         accSnap = GNT & REQ_VALID;
         tick();
         TM0 = ($urandom_range(0, 3) != 0);
         TM1 = 1'($urandom_range(0, 1));
         for (int r = 0; r < N; r++) begin
            if (accSnap[r]) begin
               left[r]--;
               hold[r] = $urandom;
               if (left[r] > 0) begin
                  if ($urandom_range(0, 15) == 0) stall[r] = 20;
                  else if ($urandom_range(0, 3) == 0) stall[r] = $urandom_range(1, 3);
                  else stall[r] = 0;
               end
            end else if (gntSnap[r] && !GNT[r] && left[r] > 0) begin
               left[r]  = 0;
               stall[r] = 0;
            end
            if (left[r] == 0 && $urandom_range(0, 3) == 0) begin
               left[r]  = $urandom_range(1, 4);
               stall[r] = 0;
               hold[r]  = $urandom;
            end
            if (left[r] > 0) begin
               if (GNT[r] && stall[r] > 0) begin
                  v = 1'b0;
                  stall[r]--;
               end else begin
                  v = 1'b1;
               end
            end else begin
               v = 1'b0;
            end
            if (v) applyStimulus(r, 1'b1, (left[r] == 1), hold[r]);
            else applyStimulus(r, 1'b0, 1'($urandom_range(0, 1)), $urandom);
         end
      end
      REQ_VALID = '0;
      REQ_LAST  = '0;
      for (int i = 0; i < 40; i++) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
